// File: rtl/mem_stage.sv
// MEM stage: latches the EXE payload, builds load/mul/alu final result, and drives forwarding and store cancel.
// Define MEM_RDATA_HOLD_EN to keep SRAM read data and the product stable while WB stalls.
module mem_stage #(
    parameter int EXC_NUM   = 6,
    parameter int ES_BUS_WD = 156 + EXC_NUM,
    parameter int MS_BUS_WD = 150 + EXC_NUM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]          data_sram_rdata,
    input  logic [64:0]          es_mul_res_bus,
    input  logic                 wb_exc,
    input  logic                 wb_ertn,
    output logic                 ms_to_ws_valid,
    output logic [MS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                 ms_to_es_st_cancel,
    output logic [37:0]          ms_fwd_bus,
    output logic [15:0]          ms_csr_blk_bus
);
    typedef struct packed {
        logic               csr_we;
        logic [13:0]        csr_wnum;
        logic [31:0]        csr_wmask;
        logic [31:0]        csr_wdata;
        logic               ertn;
        logic [EXC_NUM-1:0] exc_flgs;
        logic               res_from_mul;
        logic [4:0]         load_op;
        logic               gr_we;
        logic [4:0]         dest;
        logic [31:0]        alu_result;
        logic [31:0]        pc;
    } es_pl_t;

    es_pl_t      pl;
    logic        ms_valid;
    logic        first;
    logic        flush;
    logic        ms_ready_go;
    logic        ms_enter;
    logic        ms_leave;
    logic [31:0] rdata;
    logic [64:0] mul_bus;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_res;
    logic [31:0] mul_res;
    logic [31:0] final_result;
    logic        has_exc;
    logic        ms_gr_we;

    assign flush          = wb_exc | wb_ertn;
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_enter       = es_to_ms_valid && ms_allowin;
    assign ms_leave       = ms_valid && ms_ready_go && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
            first    <= 1'b0;
            pl       <= '0;
        end else begin
            // a flush from WB wins over an instruction entering this cycle
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            first <= ms_enter && !flush;
            if (ms_enter)
                pl <= es_to_ms_bus;
        end
    end

`ifdef MEM_RDATA_HOLD_EN
    logic        hold_vld;
    logic [31:0] hold_rdata;
    logic [64:0] hold_mul;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            hold_vld   <= 1'b0;
            hold_rdata <= '0;
            hold_mul   <= '0;
        end else if (ms_leave) begin
            hold_vld <= 1'b0;
        end else if (ms_valid && first && !ws_allowin) begin
            // SRAM and multiplier outputs are only valid in the first MEM cycle
            hold_vld   <= 1'b1;
            hold_rdata <= data_sram_rdata;
            hold_mul   <= es_mul_res_bus;
        end
    end

    assign rdata   = hold_vld ? hold_rdata : data_sram_rdata;
    assign mul_bus = hold_vld ? hold_mul   : es_mul_res_bus;
`else
    assign rdata   = data_sram_rdata;
    assign mul_bus = es_mul_res_bus;
`endif

    always_comb begin
        ld_byte = rdata[7:0];
        case (pl.alu_result[1:0])
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            2'd3: ld_byte = rdata[31:24];
        endcase
        ld_half = pl.alu_result[1] ? rdata[31:16] : rdata[15:0];

        ld_res = {16'b0, ld_half};
        if (pl.load_op[4])
            ld_res = {{24{ld_byte[7]}}, ld_byte};
        else if (pl.load_op[3])
            ld_res = {{16{ld_half[15]}}, ld_half};
        else if (pl.load_op[2])
            ld_res = rdata;
        else if (pl.load_op[1])
            ld_res = {24'b0, ld_byte};

        mul_res = mul_bus[64] ? mul_bus[63:32] : mul_bus[31:0];

        final_result = pl.alu_result;
        if (|pl.load_op)
            final_result = ld_res;
        else if (pl.res_from_mul)
            final_result = mul_res;
    end

    assign has_exc  = |pl.exc_flgs;
    assign ms_gr_we = pl.gr_we && !has_exc;

    assign ms_to_ws_bus = {pl.csr_we, pl.csr_wnum, pl.csr_wmask, pl.csr_wdata, pl.ertn,
                           pl.exc_flgs, ms_gr_we, pl.dest, final_result, pl.pc};

    assign ms_to_es_st_cancel = ms_valid && (has_exc || pl.ertn);
    assign ms_fwd_bus         = {ms_valid && ms_gr_we, pl.dest, final_result};
    assign ms_csr_blk_bus     = {pl.csr_we && ms_valid, pl.ertn && ms_valid, pl.csr_wnum};

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth stage of the five-stage LoongArch-style pipeline, between EXE and WB. It latches the EXE payload, forms the final load result from the synchronous data-SRAM read word, and selects the multiplier product half. It forwards the destination result to ID, raises store-cancel back to EXE when an exception or ertn is in flight, and holds transient SRAM and multiplier data while WB back-pressures.

## Interface
- EXC_NUM, 6, width of exception flag vector
- ES_BUS_WD, 156+EXC_NUM, es_to_ms_bus width
- MS_BUS_WD, 150+EXC_NUM, ms_to_ws_bus width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EXE payload valid
- es_to_ms_bus  in  ES_BUS_WD  MSB→LSB: csr_we, csr_wnum[13:0], csr_wmask[31:0], csr_wdata[31:0], ertn, exc_flgs[EXC_NUM-1:0], res_from_mul, load_op[4:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]
- data_sram_rdata  in  32  read word; valid only in the first MEM cycle of a load
- es_mul_res_bus  in  65  {hi_sel, product[63:0]}; valid only in the first MEM cycle of a mul
- wb_exc, wb_ertn  in  1 each  pipeline flush from WB
- ms_to_ws_valid  out  1
- ms_to_ws_bus  out  MS_BUS_WD  csr_we, csr_wnum, csr_wmask, csr_wdata, ertn, exc_flgs, gr_we, dest, final_result, pc
- ms_to_es_st_cancel  out  1  suppress EXE store
- ms_fwd_bus  out  38  {we, dest[4:0], final_result[31:0]}
- ms_csr_blk_bus  out  16  {csr_we&valid, ertn&valid, csr_wnum}

## Operation
- ms_ready_go = 1. ms_allowin = !ms_valid | ws_allowin. ms_to_ws_valid = ms_valid.
- Payload register loads when es_to_ms_valid & ms_allowin. ms_valid <= es_to_ms_valid when ms_allowin.
- first flag: set on load, cleared on the next clock edge.
- Byte lane from alu_result[1:0]; half from alu_result[1].
- load_op one-hot: [4] ld.b sign-extends byte, [3] ld.h sign-extends half, [2] ld.w whole word, [1] ld.bu zero-extends byte, [0] ld.hu zero-extends half.
- mul result: product[63:32] if hi_sel, else product[31:0].
- final_result priority: load (|load_op) > mul (res_from_mul) > alu_result.
- Any exc_flgs bit set: gr_we forced 0 on ms_to_ws_bus and ms_fwd_bus.
- ms_to_es_st_cancel = ms_valid & (|exc_flgs | ertn).
- ms_fwd_bus.we = ms_valid & gr_we & ~|exc_flgs.
- Hold path, when enabled:
  - On a first cycle with ws_allowin = 0, capture data_sram_rdata and the mul product into hold registers and set hold_vld.
  - While hold_vld = 1, the result is taken from the hold registers.
  - hold_vld clears when the instruction leaves MEM, on flush, and on reset.

## Timing
- Reset: ms_valid = 0, first = 0, hold_vld = 0. All valid-gated outputs are 0; ms_allowin = 1.
- Latency: one cycle EXE→WB. Load data arrives from the SRAM the cycle the instruction enters MEM.
- wb_exc | wb_ertn: ms_valid = 0 on the next edge, overriding a simultaneous load; hold_vld cleared.
- Simultaneous leave and enter (ws_allowin = 1, es_to_ms_valid = 1): a new payload is latched, first = 1, hold_vld = 0.
- Stalls of any length with hold enabled: final_result is stable from the first cycle to departure.

## Configuration
- MEM_RDATA_HOLD_EN defined: hold registers and hold_vld are implemented as described.
- MEM_RDATA_HOLD_EN undefined:
  - No hold registers; data_sram_rdata and es_mul_res_bus are used combinationally every cycle.
  - Legal only where ws_allowin is constantly 1.
  - A stalled load/mul yields undefined final_result.

## Test plan
- Load ld.b, alu_result=0x1003, rdata=0x80xxxxxx, ws_allowin=1 -> final_result=0xFFFFFF80 on the next cycle at WB; fwd we=1.
- ld.hu, alu_result=0x2002, rdata=0xBEEF1234, ws_allowin held 0 for 3 cycles; SRAM bus driven to 0 afterwards -> final_result=0x0000BEEF in all stall cycles (hold enabled).
- mul with hi_sel=1, product=0x00000002_00000005 -> final_result=0x00000002; with hi_sel=0 -> 0x00000005.
- Payload with ALE flag set, gr_we=1 -> ms_to_es_st_cancel=1, fwd we=0, ms_to_ws_bus gr_we=0.
- wb_exc pulse while MEM holds a stalled load and EXE presents a valid -> ms_valid=0 the next cycle, hold_vld=0, ms_allowin=1.
- Back-to-back ld.w 0x11111111, 0x22222222 with ws_allowin=1 -> WB sees both in consecutive cycles with no bubble.
